// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : grants the shared memory port to fetch (IF) or data (D).
//               One access per grant; ARB_RR_EN selects round-robin tie-break.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          last_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] c_lat = 4'(MEM_LAT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_gnt_d;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_cnt;
  logic          w_any_req;
  logic          w_win_d;

  assign w_any_req = if_req | d_req;

`ifdef ARB_RR_EN
  // On a tie, the requester that did not win last time goes first.
  assign w_win_d = d_req & (~if_req | ~last_grant);
`else
  assign w_win_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = RESP;
      end
      RESP: begin
        if_ack      = ~r_gnt_d;
        d_ack       = r_gnt_d;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // WAIT spans MEM_LAT+1 cycles: data arrives MEM_LAT cycles after the strobe cycle ends.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_gnt_d    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 4'd0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      last_grant <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt_d    <= w_win_d;
            last_grant <= w_win_d;
            r_we       <= w_win_d & d_we;
            r_addr     <= w_win_d ? d_addr : if_addr;
            r_wdata    <= w_win_d ? d_wdata : '0;
          end
        end
        ACCESS: begin
          r_cnt <= c_lat;
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              if (r_gnt_d) d_rdata  <= mem_rdata;
              else         if_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
